rr_arbiter_4_v: RTL and testbench

Four-requester round-robin arbiter that shares one downstream resource among requesters, using the same 4-bit request / 2-bit code / valid encoding as the team's priority-encoder blocks. It adds registered grants, a rotating priority pointer, grant hold while the owner keeps requesting, and a bounded hold time with forced rotation. It sits between the requester side and the shared datapath, and drives that datapath's select code.

---
 rtl/rr_arbiter_4_v.sv | 123 ++++++++++++
 tb/tb_rr_arbiter_4_v.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_4_v.sv
// Four-requester round-robin arbiter with registered grants, grant hold while the
// owner keeps requesting, and a bounded hold time that forces rotation under contention.
module rr_arbiter_4_v #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_req,
    output logic [3:0] o_gnt,
    output logic [1:0] o_gnt_id,
    output logic       o_gnt_valid,
    output logic       o_preempt
);

    localparam int unsigned HW = $clog2(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [3:0]    gnt_q, gnt_d;
    logic [1:0]    gnt_id_q, gnt_id_d;
    logic          gnt_valid_q, gnt_valid_d;
    logic          preempt_q, preempt_d;

    logic [3:0]    others;
    logic          new_grant;
    logic [1:0]    new_id;

    // First set bit of mask scanning start, start+1, ... (mod 4); scanning the
    // offsets downward lets the nearest candidate overwrite farther ones.
    function automatic logic [1:0] sel(input logic [3:0] mask, input logic [1:0] start);
        logic [1:0] idx;
        logic [1:0] res;
        res = start;
        for (int i = 3; i >= 0; i--) begin
            idx = start + 2'(i);
            if (mask[idx]) res = idx;
        end
        return res;
    endfunction

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
        preempt_d   = 1'b0;
        new_grant   = 1'b0;
        new_id      = gnt_id_q;
        others      = i_req & ~(4'b0001 << gnt_id_q);

        case (state_q)
            IDLE: begin
                if (|i_req) begin
                    new_grant = 1'b1;
                    new_id    = sel(i_req, ptr_q);
                end
            end
            GRANT: begin
                if (!i_req[gnt_id_q]) begin
                    if (|others) begin
                        new_grant = 1'b1;
                        new_id    = sel(others, gnt_id_q + 2'd1);
                    end else begin
                        state_d     = IDLE;
                        gnt_valid_d = 1'b0;
                    end
                end else if (hold_cnt_q < HOLD_LAST) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end else if (|others) begin
                    // Owner timed out while someone else waits: force rotation.
                    new_grant = 1'b1;
                    preempt_d = 1'b1;
                    new_id    = sel(others, gnt_id_q + 2'd1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (new_grant) begin
            state_d     = GRANT;
            gnt_id_d    = new_id;
            gnt_valid_d = 1'b1;
            ptr_d       = new_id + 2'd1;
            hold_cnt_d  = '0;
        end

        gnt_d = gnt_valid_d ? (4'b0001 << gnt_id_d) : 4'b0000;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            ptr_q       <= 2'd0;
            hold_cnt_q  <= '0;
            gnt_q       <= 4'b0000;
            gnt_id_q    <= 2'd0;
            gnt_valid_q <= 1'b0;
            preempt_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            preempt_q   <= preempt_d;
        end
    end

    assign o_gnt       = gnt_q;
    assign o_gnt_id    = gnt_id_q;
    assign o_gnt_valid = gnt_valid_q;
    assign o_preempt   = preempt_q;

endmodule

// File: tb/tb_rr_arbiter_4_v.sv
// Directed bench for rr_arbiter_4_v: reset, rotation, timeout preemption,
// uncontended hold and reset mid-grant, plus per-cycle output invariants.
module tb_rr_arbiter_4_v;

    logic       i_clk;
    logic       i_rst;
    logic [3:0] i_req;
    logic [3:0] o_gnt;
    logic [1:0] o_gnt_id;
    logic       o_gnt_valid;
    logic       o_preempt;

    int checks;
    int failures;
    bit inv_en;

    rr_arbiter_4_v #(.MAX_HOLD(8)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_req      (i_req),
        .o_gnt      (o_gnt),
        .o_gnt_id   (o_gnt_id),
        .o_gnt_valid(o_gnt_valid),
        .o_preempt  (o_preempt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_grant(input string tag, input logic [1:0] id, input logic pre);
        chk({tag, "_valid"}, 32'(o_gnt_valid), 32'd1);
        chk({tag, "_id"}, 32'(o_gnt_id), 32'(id));
        chk({tag, "_gnt"}, 32'(o_gnt), 32'(4'b0001 << id));
        chk({tag, "_preempt"}, 32'(o_preempt), 32'(pre));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_gnt"}, 32'(o_gnt), 32'h0);
        chk({tag, "_id"}, 32'(o_gnt_id), 32'h0);
        chk({tag, "_valid"}, 32'(o_gnt_valid), 32'h0);
        chk({tag, "_preempt"}, 32'(o_preempt), 32'h0);
        chk({tag, "_ptr"}, 32'(dut.ptr_q), 32'h0);
    endtask

    // Output invariants sampled on the falling edge once the first reset has been applied.
    always @(negedge i_clk) begin
        if (inv_en) begin
            checks++;
            assert (!$isunknown({o_gnt, o_gnt_id, o_gnt_valid, o_preempt})) else begin
                failures++;
                $error("FAIL inv_noX observed=%b expected=no_X", {o_gnt, o_gnt_id, o_gnt_valid, o_preempt});
            end
            checks++;
            assert ($onehot0(o_gnt)) else begin
                failures++;
                $error("FAIL inv_onehot observed=%b expected=onehot0", o_gnt);
            end
            checks++;
            assert (o_gnt === (o_gnt_valid ? (4'b0001 << o_gnt_id) : 4'b0000)) else begin
                failures++;
                $error("FAIL inv_gnt_match observed=%b expected=%b", o_gnt,
                       o_gnt_valid ? (4'b0001 << o_gnt_id) : 4'b0000);
            end
        end
    end

    initial begin
        logic [1:0] rot_id [5];
        logic [3:0] rot_req [5];

        checks   = 0;
        failures = 0;
        inv_en   = 1'b0;
        i_rst    = 1'b1;
        i_req    = 4'b0000;

        // Reset and single request
        tick();
        chk_reset_vals("rst1");
        inv_en = 1'b1;
        tick();
        chk_reset_vals("rst2");
        i_rst = 1'b0;
        i_req = 4'b0100;
        tick();
        chk_grant("single", 2'd2, 1'b0);
        chk("single_ptr", 32'(dut.ptr_q), 32'd3);
        i_req = 4'b0000;
        tick();
        chk("drop_valid", 32'(o_gnt_valid), 32'd0);
        chk("drop_gnt", 32'(o_gnt), 32'd0);
        chk("drop_id_hold", 32'(o_gnt_id), 32'd2);

        // Fair rotation: each owner drops its bit for one cycle
        i_rst = 1'b1;
        tick();
        chk_reset_vals("rst3");
        i_rst = 1'b0;
        rot_req[0] = 4'b1111; rot_id[0] = 2'd0;
        rot_req[1] = 4'b1110; rot_id[1] = 2'd1;
        rot_req[2] = 4'b1101; rot_id[2] = 2'd2;
        rot_req[3] = 4'b1011; rot_id[3] = 2'd3;
        rot_req[4] = 4'b0111; rot_id[4] = 2'd0;
        for (int k = 0; k < 5; k++) begin
            i_req = rot_req[k];
            tick();
            chk_grant($sformatf("rot%0d", k), rot_id[k], 1'b0);
        end
        i_req = 4'b0000;
        tick();
        chk("rot_idle", 32'(o_gnt_valid), 32'd0);

        // Timeout preemption with two contending requesters
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        i_req = 4'b0011;
        tick();
        for (int k = 0; k < 8; k++) begin
            chk_grant($sformatf("to_r0_c%0d", k), 2'd0, 1'b0);
            tick();
        end
        chk_grant("to_pre1", 2'd1, 1'b1);
        for (int k = 1; k < 8; k++) begin
            tick();
            chk_grant($sformatf("to_r1_c%0d", k), 2'd1, 1'b0);
        end
        tick();
        chk_grant("to_pre0", 2'd0, 1'b1);

        // Uncontended hold: owner 0 drops, requester 3 takes over and keeps it
        i_req = 4'b1000;
        tick();
        chk_grant("unc_c0", 2'd3, 1'b0);
        for (int k = 1; k < 20; k++) begin
            tick();
            chk_grant($sformatf("unc_c%0d", k), 2'd3, 1'b0);
        end
        chk("unc_hold_sat", 32'(dut.hold_cnt_q), 32'd7);
        i_req = 4'b0000;
        tick();
        chk("unc_release", 32'(o_gnt_valid), 32'd0);

        // Reset mid-grant coinciding with request changes
        i_req = 4'b0100;
        tick();
        chk_grant("mid_r2", 2'd2, 1'b0);
        i_rst = 1'b1;
        i_req = 4'b1000;
        tick();
        chk_reset_vals("mid_rst");
        i_rst = 1'b0;
        i_req = 4'b1100;
        tick();
        chk_grant("post_rst", 2'd2, 1'b0);
        i_req = 4'b0000;
        tick();
        chk("end_idle", 32'(o_gnt_valid), 32'd0);

        inv_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
